// File: rtl/mem_write_checker_if.sv
// Data-memory store bus of the pipelined MIPS core, as seen by a checker.
//   memwrite  : store strobe
//   dataadr   : store address  (ADDR_W bits)
//   writedata : store data     (DATA_W bits)
// master : the side that drives stores (core or bench)
// slave  : the side that observes stores (checker)
interface mem_write_checker_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              memwrite;
  logic [ADDR_W-1:0] dataadr;
  logic [DATA_W-1:0] writedata;

  modport master (output memwrite, output dataadr, output writedata);
  modport slave  (input  memwrite, input  dataadr, input  writedata);
endinterface

// File: rtl/mem_write_checker.sv
// Registered self-check monitor for the MIPS core's data-memory write port.
// Classifies stores while running, detects the pass store, records illegal
// stores and times out after TIMEOUT_CYCLES run cycles.
// Ports:
//   clk, rst     : clock (rising edge), synchronous active-high reset
//   en           : start pulse, only sampled while idle
//   bus          : store bus (memwrite / dataadr / writedata), slave side
//   state        : 00 idle, 01 run, 10 done, 11 timeout
//   done         : state is done or timeout
//   pass         : finished on a correct pass store with no illegal stores
//   fail         : sticky failure flag
//   cycle_count  : cycles spent running
//   write_count  : stores seen while running
//   fail_count   : illegal or bad-pass stores seen while running
//   fail_addr    : address of the first failing store
//   fail_data    : data of the first failing store
module mem_write_checker #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned PASS_ADDR      = 84,
  parameter int unsigned PASS_DATA      = 7,
  parameter int unsigned IGNORE_ADDR    = 80,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned CNT_W          = 16,
  parameter bit          STOP_ON_FAIL   = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  mem_write_checker_if.slave bus,
  output logic [1:0]        state,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  write_count,
  output logic [CNT_W-1:0]  fail_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    DONE    = 2'b10,
    TIMEOUT = 2'b11
  } state_t;

  localparam logic [ADDR_W-1:0] passAddr    = ADDR_W'(PASS_ADDR);
  localparam logic [DATA_W-1:0] passData    = DATA_W'(PASS_DATA);
  localparam logic [ADDR_W-1:0] ignoreAddr  = ADDR_W'(IGNORE_ADDR);
  // Compared at 64 bits so a limit wider than CNT_W never aliases.
  localparam logic [63:0]       timeoutLast = 64'(TIMEOUT_CYCLES) - 64'd1;

  state_t curState;

  logic passOk;
  logic passBad;
  logic illegal;
  logic badStore;
  logic lastCycle;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // Store classification; the pass address wins over the ignore address.
  always_comb begin
    passOk    = 1'b0;
    passBad   = 1'b0;
    illegal   = 1'b0;
    if (bus.memwrite) begin
      if (bus.dataadr == passAddr) begin
        passOk  = (bus.writedata == passData);
        passBad = (bus.writedata != passData);
      end else if (bus.dataadr != ignoreAddr) begin
        illegal = 1'b1;
      end
    end
    badStore  = passBad | illegal;
    lastCycle = (64'(cycle_count) == timeoutLast);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      curState    <= IDLE;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      cycle_count <= '0;
      write_count <= '0;
      fail_count  <= '0;
      fail_addr   <= '0;
      fail_data   <= '0;
    end else begin
      unique case (curState)
        IDLE: begin
          if (en) curState <= RUN;
        end
        RUN: begin
          // The timeout edge itself is not counted, so cycle_count ends at
          // TIMEOUT_CYCLES-1.
          if (!lastCycle) cycle_count <= satInc(cycle_count);
          if (bus.memwrite) write_count <= satInc(write_count);
          if (badStore) begin
            fail_count <= satInc(fail_count);
            fail       <= 1'b1;
            // fail can only be set by a failing store before this point
            // (timeout is terminal), so it doubles as the captured flag.
            if (!fail) begin
              fail_addr <= bus.dataadr;
              fail_data <= bus.writedata;
            end
          end
          if (passOk || passBad) begin
            curState <= DONE;
            done     <= 1'b1;
            pass     <= passOk && (fail_count == '0);
          end else if (lastCycle) begin
            curState <= TIMEOUT;
            done     <= 1'b1;
            fail     <= 1'b1;
          end else if (illegal && STOP_ON_FAIL) begin
            curState <= DONE;
            done     <= 1'b1;
          end
        end
        default: ;  // DONE and TIMEOUT hold until reset
      endcase
    end
  end

  assign state = curState;

endmodule

// File: tb/tb_mem_write_checker.sv
module tb_mem_write_checker;

  localparam int T = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;
  logic snap = 1'b0;
  always #5 clk = ~clk;

  mem_write_checker_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  logic [1:0]  state0, state1;
  logic        done0, done1, pass0, pass1, fail0, fail1;
  logic [15:0] cyc0, cyc1, wc0, wc1, fc0, fc1;
  logic [31:0] fa0, fa1, fd0, fd1;

  mem_write_checker #(.TIMEOUT_CYCLES(T), .STOP_ON_FAIL(1'b0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .bus(bus),
    .state(state0), .done(done0), .pass(pass0), .fail(fail0),
    .cycle_count(cyc0), .write_count(wc0), .fail_count(fc0),
    .fail_addr(fa0), .fail_data(fd0));

  mem_write_checker #(.TIMEOUT_CYCLES(T), .STOP_ON_FAIL(1'b1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .bus(bus),
    .state(state1), .done(done1), .pass(pass1), .fail(fail1),
    .cycle_count(cyc1), .write_count(wc1), .fail_count(fc1),
    .fail_addr(fa1), .fail_data(fd1));

  // Reference model: states 0 idle, 1 run, 2 done, 3 timeout.
  typedef struct {
    int          st;
    bit          pass;
    bit          fail;
    bit          cap;
    int          cyc;
    int          wc;
    int          fc;
    logic [31:0] fa;
    logic [31:0] fd;
  } model_t;

  model_t m0, m1;
  model_t doneQ0[$], doneQ1[$], snapQ0[$], snapQ1[$];

  int checks = 0;
  int failures = 0;

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  function automatic model_t resetModel();
    model_t r;
    r.st = 0; r.pass = 0; r.fail = 0; r.cap = 0;
    r.cyc = 0; r.wc = 0; r.fc = 0; r.fa = '0; r.fd = '0;
    return r;
  endfunction

  function automatic model_t step(input model_t m, input bit stop, input bit r,
                                  input bit e, input bit mw,
                                  input logic [31:0] a, input logic [31:0] d);
    bit isPass, ok, bad, last;
    if (r) return resetModel();
    if (m.st == 0) begin
      if (e) m.st = 1;
      return m;
    end
    if (m.st != 1) return m;
    isPass = mw && (a == 32'd84);
    ok     = isPass && (d == 32'd7);
    bad    = mw && !ok && (a != 32'd80);  // bad pass data or illegal address
    last   = (m.cyc == T - 1);
    if (mw) m.wc = sat(m.wc + 1);
    if (bad) begin
      m.fc = sat(m.fc + 1);
      m.fail = 1;
      if (!m.cap) begin
        m.cap = 1; m.fa = a; m.fd = d;
      end
    end
    if (!last) m.cyc = sat(m.cyc + 1);
    if (isPass) begin
      m.st = 2;
      m.pass = ok && (m.fc == 0);
    end else if (last) begin
      m.st = 3;
      m.fail = 1;
    end else if (bad && stop) begin
      m.st = 2;
    end
    return m;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic compareDut(input string tag, input int which, input model_t e);
    logic [1:0]  s;
    logic        d, p, f;
    logic [15:0] c, w, fc;
    logic [31:0] fa, fd;
    if (which == 0) begin
      s = state0; d = done0; p = pass0; f = fail0; c = cyc0; w = wc0; fc = fc0; fa = fa0; fd = fd0;
    end else begin
      s = state1; d = done1; p = pass1; f = fail1; c = cyc1; w = wc1; fc = fc1; fa = fa1; fd = fd1;
    end
    chk({tag, ".state"},       64'(s),  64'(e.st));
    chk({tag, ".done"},        64'(d),  64'(e.st >= 2));
    chk({tag, ".pass"},        64'(p),  64'(e.pass));
    chk({tag, ".fail"},        64'(f),  64'(e.fail));
    chk({tag, ".cycle_count"}, 64'(c),  64'(e.cyc));
    chk({tag, ".write_count"}, 64'(w),  64'(e.wc));
    chk({tag, ".fail_count"},  64'(fc), 64'(e.fc));
    chk({tag, ".fail_addr"},   64'(fa), 64'(e.fa));
    chk({tag, ".fail_data"},   64'(fd), 64'(e.fd));
  endtask

  // Monitor: pops an expectation whenever a checker raises done, and on
  // snapshot requests from the stimulus.
  bit prev0 = 0, prev1 = 0;
  always @(negedge clk) begin
    if (done0 === 1'b1 && !prev0) begin
      if (doneQ0.size() == 0) chk("d0.unexpected_done", 64'd1, 64'd0);
      else compareDut("d0.done_evt", 0, doneQ0.pop_front());
    end
    if (done1 === 1'b1 && !prev1) begin
      if (doneQ1.size() == 0) chk("d1.unexpected_done", 64'd1, 64'd0);
      else compareDut("d1.done_evt", 1, doneQ1.pop_front());
    end
    prev0 = (done0 === 1'b1);
    prev1 = (done1 === 1'b1);
    if (snap) begin
      if (snapQ0.size() != 0) compareDut("d0.snap", 0, snapQ0.pop_front());
      if (snapQ1.size() != 0) compareDut("d1.snap", 1, snapQ1.pop_front());
    end
  end

  task automatic tick(input bit r, input bit e, input bit mw,
                      input logic [31:0] a, input logic [31:0] d);
    int old0, old1;
    rst = r; en = e;
    bus.memwrite = mw; bus.dataadr = a; bus.writedata = d;
    old0 = m0.st; old1 = m1.st;
    m0 = step(m0, 1'b0, r, e, mw, a, d);
    m1 = step(m1, 1'b1, r, e, mw, a, d);
    if (old0 == 1 && m0.st >= 2) doneQ0.push_back(m0);
    if (old1 == 1 && m1.st >= 2) doneQ1.push_back(m1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tick(0, 0, 0, '0, '0);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    tick(0, 0, 1, a, d);
  endtask

  task automatic start();
    tick(1, 0, 0, '0, '0);
    tick(0, 1, 0, '0, '0);
  endtask

  // Monitor sees outputs of the previous edge during this idle cycle.
  task automatic snapshot();
    snapQ0.push_back(m0);
    snapQ1.push_back(m1);
    snap = 1;
    idle();
    snap = 0;
  endtask

  function automatic logic [31:0] randAddr();
    int k = $urandom_range(0, 9);
    if (k <= 2) return 32'd80;
    if (k <= 4) return 32'd84;
    if (k <= 7) return 32'd88 + 32'(4 * $urandom_range(0, 7));
    return $urandom;
  endfunction

  function automatic logic [31:0] randData(input logic [31:0] a);
    if (a == 32'd84 && $urandom_range(0, 9) < 7) return 32'd7;
    return 32'($urandom_range(0, 15));
  endfunction

  initial begin
    logic [31:0] a;
    m0 = resetModel();
    m1 = resetModel();
    bus.memwrite = 0; bus.dataadr = '0; bus.writedata = '0;
    @(posedge clk); #1;

    // Reset state
    tick(1, 0, 0, '0, '0);
    snapshot();

    // Ignored stores then a good pass store
    start();
    store(80, 5); store(80, 12); store(84, 7);
    idle(); snapshot();

    // Illegal stores then pass; second store after stop is frozen out
    start();
    store(88, 1); store(92, 2); store(84, 7);
    idle(); snapshot();

    // Wrong pass data
    start();
    store(84, 6);
    idle(); snapshot();

    // Pure timeout
    start();
    repeat (T) idle();
    idle(); snapshot();

    // Pass store on the timeout edge
    start();
    repeat (T - 1) idle();
    store(84, 7);
    idle(); snapshot();

    // Illegal store on the timeout edge
    start();
    repeat (T - 1) idle();
    store(88, 1);
    idle(); snapshot();

    // Reset mid-run with other inputs active, then idle stores
    start();
    store(80, 1); store(80, 2); store(80, 3);
    tick(1, 1, 1, 88, 1);
    snapshot();
    store(88, 1); store(84, 7);
    snapshot();
    // en and a store in the same idle cycle: store not classified
    tick(0, 1, 1, 88, 1);
    snapshot();

    // Randomized runs
    for (int s = 0; s < 60; s++) begin
      a = randAddr();
      tick(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, randData(a));
      for (int g = 0, n = $urandom_range(0, 3); g < n; g++) begin
        a = randAddr();
        tick(0, 0, 1'($urandom_range(0, 1)), a, randData(a));
      end
      a = randAddr();
      tick(0, 1, 1'($urandom_range(0, 1)), a, randData(a));
      for (int c = 0, n = $urandom_range(1, 22); c < n; c++) begin
        a = randAddr();
        tick(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, randData(a));
      end
      idle();
      snapshot();
    end

    idle(); idle();
    chk("d0.pending_done", 64'(doneQ0.size()), 64'd0);
    chk("d1.pending_done", 64'(doneQ1.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
